// File: rtl/math_seq.sv
// math_seq: sequential unsigned multiplier (shift-add) and restoring divider,
// one algorithm step per cycle over W cycles.
module math_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem,
  output logic           div0
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_op;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_mc;
  logic [W-1:0]   r_mb;
  logic [2*W-1:0] r_acc;
  logic [W:0]     r_pr;
  logic [W-1:0]   r_q;
  logic           r_busy, r_done, r_div0;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_quot, r_rem;
  logic [2*W-1:0] w_acc_n;
  logic [W:0]     w_sh;
  logic [W+1:0]   w_sub;
  logic           w_neg;
  logic [W:0]     w_pr_n;
  logic [W-1:0]   w_q_n;
  logic           w_last;
  always_comb begin
    w_acc_n = r_mb[0] ? r_acc + r_mc : r_acc;
    w_sh    = {r_pr[W-1:0], r_q[W-1]};
    w_sub   = {1'b0, w_sh} - {2'b0, r_b};
    w_neg   = w_sub[W+1];
    w_pr_n  = w_neg ? w_sh : w_sub[W:0];
    w_q_n   = {r_q[W-2:0], ~w_neg};
    w_last  = r_cnt == CW'(W-1);
  end
  // A zero divisor never borrows, so the quotient fills with ones and the
  // dividend shifts intact into the remainder without any special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_b     <= '0;
      r_mc    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_pr    <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_prod  <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_div0  <= 1'b0;
    end else if (r_state != RUN && start) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_op    <= op;
      r_b     <= b;
      r_mc    <= {{W{1'b0}}, a};
      r_mb    <= b;
      r_acc   <= '0;
      r_pr    <= '0;
      r_q     <= a;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_mc  <= r_mc << 1;
      r_mb  <= r_mb >> 1;
      r_acc <= w_acc_n;
      r_pr  <= w_pr_n;
      r_q   <= w_q_n;
      if (w_last) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        if (r_op) begin
          r_quot <= w_q_n;
          r_rem  <= w_pr_n[W-1:0];
          r_div0 <= r_b == '0;
        end else begin
          r_prod <= w_acc_n;
        end
      end
    end else if (r_state == DONE) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign prod = r_prod;
  assign quot = r_quot;
  assign rem  = r_rem;
  assign div0 = r_div0;
endmodule

// File: tb/tb_math_seq.sv
// tb_math_seq: scoreboard bench for math_seq at W=4, directed cases plus
// an exhaustive sweep of both operations.
module tb_math_seq;
  localparam int W = 4;
  logic           clk, rst, start, op, busy, done, div0;
  logic [W-1:0]   a, b, quot, rem;
  logic [2*W-1:0] prod;
  typedef struct {
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           div0;
  } exp_t;
  exp_t           sbq[$];
  logic [2*W-1:0] m_prod;
  logic [W-1:0]   m_quot, m_rem;
  logic           m_div0;
  int             n_chk, n_fail, n_done;
  math_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .prod(prod), .quot(quot), .rem(rem), .div0(div0)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_exp(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    if (o) begin
      m_quot = (y == 0) ? {W{1'b1}} : x / y;
      m_rem  = (y == 0) ? x : x % y;
      m_div0 = (y == 0);
    end else begin
      m_prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end
    e.prod = m_prod; e.quot = m_quot; e.rem = m_rem; e.div0 = m_div0;
    sbq.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (done) begin
      exp_t e;
      n_done++;
      if (sbq.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("prod", prod, e.prod);
        chk("quot", quot, e.quot);
        chk("rem", rem, e.rem);
        chk("div0", div0, e.div0);
      end
    end
  end
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    push_exp(o, x, y);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int lat);
    int k, nb;
    k = 0; nb = 0;
    while (!done && k < 20) begin
      if (busy) nb++;
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk({tag, "_timeout"}, 0, 1);
    else if (lat > 0) begin
      chk({tag, "_lat"}, k + 1, lat);
      chk({tag, "_busy"}, nb, lat - 1);
      chk({tag, "_busy_at_done"}, busy, 0);
    end
  endtask
  initial begin
    int d0;
    n_chk = 0; n_fail = 0; n_done = 0;
    m_prod = '0; m_quot = '0; m_rem = '0; m_div0 = 1'b0;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", prod, 0);
    chk("rst_quot", quot, 0);
    chk("rst_div0", div0, 0);
    rst = 1'b0;
    issue(1'b0, 4'd15, 4'd15);
    wait_done("mul15x15", W + 1);
    issue(1'b1, 4'd13, 4'd4);
    wait_done("div13_4", W + 1);
    issue(1'b1, 4'd9, 4'd2);
    wait_done("div9_2", W + 1);
    issue(1'b1, 4'd7, 4'd0);
    wait_done("div7_0", W + 1);
    d0 = n_done;
    issue(1'b0, 4'd3, 4'd5);
    op = 1'b1; a = 4'd9; b = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul3x5_ignore", 0);
    repeat (8) @(negedge clk);
    chk("ignore_single_done", n_done - d0, 1);
    issue(1'b1, 4'd14, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    m_prod = '0; m_quot = '0; m_rem = '0; m_div0 = 1'b0;
    chk("rrun_busy", busy, 0);
    chk("rrun_done", done, 0);
    chk("rrun_prod", prod, 0);
    chk("rrun_quot", quot, 0);
    chk("rrun_rem", rem, 0);
    chk("rrun_div0", div0, 0);
    d0 = n_done;
    repeat (8) @(negedge clk);
    chk("rrun_no_done", n_done - d0, 0);
    issue(1'b0, 4'd2, 4'd4);
    wait_done("mul2x4", W + 1);
    @(negedge clk);
    op = 1'b0; a = 4'd6; b = 4'd7; start = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(1'b0, 4'd6, 4'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wait_done("cont6x7", W + 1);
    end
    start = 1'b0;
    for (int o = 0; o < 2; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          issue(o[0], x[W-1:0], y[W-1:0]);
          wait_done("sweep", 0);
        end
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/math_seq.md
MATH_SEQ -- requirements
Module: math_seq

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only when busy=0.
REQ-005 The block SHALL have port op, input, 1 bit: operation select; 0=MUL, 1=DIVMOD; captured with start.
REQ-006 The block SHALL have port a, input, W bits: unsigned multiplicand or dividend; captured with start.
REQ-007 The block SHALL have port b, input, W bits: unsigned multiplier or divisor; captured with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is running.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse when results become valid.
REQ-010 The block SHALL have port prod, output, 2W bits: a*b result for MUL.
REQ-011 The block SHALL have port quot, output, W bits: a/b result for DIVMOD.
REQ-012 The block SHALL have port rem, output, W bits: a%b result for DIVMOD.
REQ-013 The block SHALL have port div0, output, 1 bit: high when the last DIVMOD had b=0.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture op, a and b, clear the step counter, and move the FSM to RUN.
REQ-016 In DONE, start=0 SHALL move the FSM to IDLE; DONE lasts exactly one cycle.
REQ-017 RUN SHALL last exactly W cycles, one algorithm step per cycle, and then move to DONE.
REQ-018 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-019 start SHALL be ignored while busy=1, with no effect on captured operands or progress.
REQ-020 Latency: start sampled high at edge T SHALL give done=1 during the cycle after edge T+W, i.e. W+1 cycles from acceptance to done.
REQ-021 Back-to-back: start during the DONE cycle SHALL be accepted, so done pulses again W+1 cycles later.
REQ-022 MUL SHALL use shift-add, one multiplier bit per step, LSB first, with a 2W-bit accumulator; the result SHALL be exact (no overflow possible).
REQ-023 DIVMOD SHALL use restoring division, one quotient bit per step, MSB first, with a (W+1)-bit partial remainder.
REQ-024 DIVMOD with b=0 SHALL complete with normal latency and give quot = all ones, rem = a, div0 = 1.
REQ-025 DIVMOD with b≠0 SHALL set div0 = 0.
REQ-026 prod, quot, rem and div0 SHALL update only on the edge entering DONE.
REQ-027 These outputs SHALL then hold until the next completion or reset.
REQ-028 A MUL SHALL leave quot, rem and div0 unchanged; a DIVMOD SHALL leave prod unchanged.
REQ-029 Changes on a, b or op after acceptance SHALL NOT affect the running operation.
REQ-030 Power-of-two divisors SHALL need no special-casing: a/2, a%2, a/4, a%4 and a*2, a*4 SHALL come from the general algorithm.

Reset
REQ-031 rst=1 at a clock edge SHALL force the FSM to IDLE and set busy, done, prod, quot, rem and div0 to 0, overriding start.
REQ-032 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow it.
REQ-033 After rst deasserts, the first start SHALL be accepted on the next edge.

Verification (W=4)
REQ-034 The bench SHALL check: MUL a=15, b=15 -> after 5 cycles done=1, prod=225, busy was 1 for exactly 4 cycles.
REQ-035 The bench SHALL check: DIVMOD a=13, b=4 -> quot=3, rem=1, div0=0; then DIVMOD a=9, b=2 -> quot=4, rem=1.
REQ-036 The bench SHALL check: DIVMOD a=7, b=0 -> quot=15, rem=7, div0=1, latency 5 cycles.
REQ-037 The bench SHALL check: MUL 3*5 accepted, then start with a=9, b=9 pulsed during RUN -> a single done with prod=15.
REQ-038 The bench SHALL check: DIVMOD 14/3 started, rst on the 2nd RUN cycle -> all outputs 0, no done; a new MUL 2*4 afterwards gives prod=8.
REQ-039 The bench SHALL check: start held high continuously with MUL 6*7 -> done every 5 cycles, prod=42 each time; and an exhaustive sweep of all a,b pairs for both ops against a reference model.
